// File: rtl/i2s_tx_param.sv
// i2s_tx_param -- parameterised I2S transmitter with a one-entry sample holding register.
//
// Purpose
//   Serialises stereo sample pairs onto a standard I2S link (MSB first, word
//   select leading the slot by one bit clock). All timing is derived from clk48m
//   by a programmable divider. A single holding register decouples the producer
//   from frame timing. If the holding register is empty at a frame boundary, an
//   offered pair is loaded directly. If no pair is offered either, a silent frame
//   is sent and underrun pulses.
//
// Parameters
//   DATA_W   sample width per channel (8..32)
//   SLOT_W   sclk periods per channel slot (>= DATA_W)
//   SCLK_DIV clk48m cycles per sclk half-period (>= 1)
//
// Ports
//   clk48m        in   sole clock, rising edge
//   rst           in   synchronous reset, active-high
//   in_left       in   left sample (two's complement)
//   in_right      in   right sample (two's complement)
//   in_valid      in   sample pair offered
//   in_ready      out  holding register empty
//   sclk          out  I2S bit clock
//   lrclk         out  I2S word select (0 = left, 1 = right)
//   dout          out  I2S serial data
//   underrun      out  one-cycle pulse: frame started with no sample available
//   underrun_cnt  out  16-bit saturating underrun count (only with I2S_TX_UNDERRUN_CNT_EN)
//
// Build option
//   I2S_TX_UNDERRUN_CNT_EN  adds the underrun_cnt port and its counter.
//
// Handshake: a pair transfers on a rising clk48m edge where in_valid && in_ready.
// in_ready depends only on internal state (~hold_full), never on in_valid.
// The producer must hold in_left/in_right stable while in_valid is high and
// in_ready is low; such offers are ignored until in_ready returns high.

module i2s_tx_param #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 16,
  parameter int SCLK_DIV = 8
) (
  input  logic              clk48m,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sclk,
  output logic              lrclk,
  output logic              dout,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  output logic              underrun
);

  localparam int DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW  = $clog2(2 * SLOT_W);

  localparam logic [DCW-1:0] DC_LAST  = DCW'(SCLK_DIV - 1);
  localparam logic [BW-1:0]  B_LAST   = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0]  B_SLOT   = BW'(SLOT_W);
  localparam logic [BW-1:0]  B_LR_ON  = BW'(SLOT_W - 1);

  logic [DCW-1:0]    r_dcnt;
  logic              r_sclk;
  logic [BW-1:0]     r_bcnt;
  logic              r_lrclk;
  logic              r_dout;
  logic              r_underrun;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_frame_l;
  logic [DATA_W-1:0] r_frame_r;

  logic              w_wrap;
  logic              w_fall;
  logic              w_load;
  logic              w_xfer;
  logic [BW-1:0]     w_bcnt_nxt;
  logic              w_hold_full_nxt;
  logic [DATA_W-1:0] w_hold_l_nxt;
  logic [DATA_W-1:0] w_hold_r_nxt;
  logic [DATA_W-1:0] w_frame_l_nxt;
  logic [DATA_W-1:0] w_frame_r_nxt;
  logic              w_underrun_nxt;
  logic              w_right_slot;
  logic [BW-1:0]     w_b;
  logic [DATA_W-1:0] w_sample;
  logic [DATA_W-1:0] w_shifted;
  logic              w_dout_nxt;
  logic              w_lrclk_nxt;

  assign w_wrap     = (r_dcnt == DC_LAST);
  // sclk is about to toggle from 1 to 0: this is the only point where the
  // bit position and the serial outputs move.
  assign w_fall     = w_wrap && r_sclk;
  assign w_bcnt_nxt = (r_bcnt == B_LAST) ? '0 : r_bcnt + 1'b1;
  assign w_load     = w_fall && (r_bcnt == B_LAST);
  assign w_xfer     = in_valid && !r_hold_full;

  // Holding register / frame register / underrun decision.
  always_comb begin
    w_hold_full_nxt = r_hold_full;
    w_hold_l_nxt    = r_hold_l;
    w_hold_r_nxt    = r_hold_r;
    w_frame_l_nxt   = r_frame_l;
    w_frame_r_nxt   = r_frame_r;
    w_underrun_nxt  = 1'b0;
    if (w_load) begin
      if (r_hold_full) begin
        w_frame_l_nxt   = r_hold_l;
        w_frame_r_nxt   = r_hold_r;
        w_hold_full_nxt = 1'b0;
      end else if (in_valid) begin
        // Bypass: the offered pair goes straight into the frame.
        w_frame_l_nxt = in_left;
        w_frame_r_nxt = in_right;
      end else begin
        w_frame_l_nxt  = '0;
        w_frame_r_nxt  = '0;
        w_underrun_nxt = 1'b1;
      end
    end else if (w_xfer) begin
      w_hold_l_nxt    = in_left;
      w_hold_r_nxt    = in_right;
      w_hold_full_nxt = 1'b1;
    end
  end

  // Serial data for the upcoming bit position. Shifting left by the in-slot
  // index brings the wanted bit to the MSB; padding positions past DATA_W
  // shift every data bit out and naturally produce 0.
  always_comb begin
    w_right_slot = (w_bcnt_nxt >= B_SLOT);
    w_b          = w_right_slot ? (w_bcnt_nxt - B_SLOT) : w_bcnt_nxt;
    w_sample     = w_right_slot ? w_frame_r_nxt : w_frame_l_nxt;
    w_shifted    = w_sample << w_b;
    w_dout_nxt   = w_shifted[DATA_W-1];
    // Word select leads the slot by one bit: high from SLOT_W-1 to 2*SLOT_W-2.
    w_lrclk_nxt  = (w_bcnt_nxt >= B_LR_ON) && (w_bcnt_nxt != B_LAST);
  end

  always_ff @(posedge clk48m) begin
    if (rst) begin
      r_dcnt      <= '0;
      r_sclk      <= 1'b0;
      r_bcnt      <= B_LAST;
      r_lrclk     <= 1'b0;
      r_dout      <= 1'b0;
      r_underrun  <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_frame_l   <= '0;
      r_frame_r   <= '0;
    end else begin
      r_dcnt <= w_wrap ? '0 : r_dcnt + 1'b1;
      if (w_wrap) begin
        r_sclk <= !r_sclk;
      end
      if (w_fall) begin
        r_bcnt  <= w_bcnt_nxt;
        r_lrclk <= w_lrclk_nxt;
        r_dout  <= w_dout_nxt;
      end
      r_underrun  <= w_underrun_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_hold_l    <= w_hold_l_nxt;
      r_hold_r    <= w_hold_r_nxt;
      r_frame_l   <= w_frame_l_nxt;
      r_frame_r   <= w_frame_r_nxt;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk48m) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_nxt && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign in_ready = !r_hold_full;
  assign sclk     = r_sclk;
  assign lrclk    = r_lrclk;
  assign dout     = r_dout;
  assign underrun = r_underrun;

endmodule
